mem_arbiter_dp: RTL and testbench
=================================

# mem_arbiter_dp

Two-to-one memory arbiter between the pipelined LC-3 core's split ports and a single-ported physical memory. Port A (instruction fetch) and port B (data access) keep the same request/response handshake the core already uses. The arbiter serialises them onto one downstream port, latches each granted request, and returns a one-cycle response with registered read data to the winning port.

## Interface
- No parameters; widths are fixed by the LC-3 16-bit datapath.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- read_a / write_a  in  1  port A read / write request, held until resp_a
- wmask_a  in  2  port A byte write mask
- address_a  in  16  port A address
- wdata_a  in  16  port A write data
- resp_a  out  1  port A completion pulse
- rdata_a  out  16  port A read data, valid with resp_a
- read_b, write_b, wmask_b, address_b, wdata_b, resp_b, rdata_b  same as port A, for port B
- pmem_read / pmem_write  out  1  downstream request, held until pmem_resp
- pmem_wmask  out  2  downstream byte mask
- pmem_address  out  16  downstream address
- pmem_wdata  out  16  downstream write data
- pmem_resp  in  1  downstream completion pulse
- pmem_rdata  in  16  downstream read data, valid with pmem_resp

## Operation
- FSM states: IDLE, SERVE, DONE.
- IDLE:
  - A port is pending if it asserts read or write.
  - If any port is pending, grant one, latch its op, address, wdata and wmask, then go to SERVE.
- Write precedence: read and write asserted together on one port is treated as a write.
- Fixed priority (default): B wins over A when both are pending.
- SERVE:
  - pmem_read/pmem_write, pmem_address, pmem_wdata and pmem_wmask are driven from the latched request only.
  - Input changes during SERVE are ignored.
  - On pmem_resp: capture pmem_rdata into the granted port's rdata register (reads only), then go to DONE.
- DONE:
  - resp of the granted port is high for exactly one cycle, then IDLE.
  - pmem_read/pmem_write are low.
- rdata_a/rdata_b hold their last captured value.
  - Writes do not update them.
  - The ungranted port's rdata never changes.
- pmem_resp received in IDLE or DONE is ignored.

## Timing
- Reset values: all outputs 0, rdata_a = rdata_b = 16'h0000, state IDLE, latched request cleared, round-robin pointer points to A.
- Request seen at edge N:
  - pmem request high from cycle N+1.
  - pmem_resp at edge M (M ≥ N+1) → resp_x high in cycle M+1, low at M+2.
  - Minimum latency is 3 cycles from request assertion to resp.
- The requester drops or replaces its request after seeing resp. The IDLE cycle following DONE samples only that new value, so there is no double service.
- Back-to-back requests on one port: one idle cycle between transactions (IDLE→SERVE).
- Reset asserted mid-transaction:
  - pmem_read/pmem_write and resp_x drop immediately (asynchronously).
  - The transaction is abandoned and no resp is issued.
  - A late pmem_resp after reset release is ignored in IDLE.
- pmem outputs are registered. No combinational path exists from port inputs to pmem outputs, or from pmem_resp to resp_x.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both ports are pending in IDLE, the port not granted last wins.
  - The pointer updates on every grant.
  - A single pending port is always granted regardless of the pointer.
- Undefined: fixed priority, B over A. The pointer logic is absent.

## Test plan
- Read on A only, address 16'h3000, memory returns 16'h1234 after 2-cycle delay → pmem_read high cycles 1–3, resp_a pulse in cycle 4 with rdata_a = 16'h1234, rdata_b unchanged.
- A read 16'h3000 and B write 16'h4000/wdata 16'hBEEF/wmask 2'b01 asserted same cycle:
  - Default: B served first (pmem_write, mask 01), then A.
  - With ARB_ROUND_ROBIN_EN: A first after reset, then B.
- Port A holds read continuously across 3 transactions at addresses 16'h3000, 16'h3001, 16'h3002 → exactly 3 pmem reads, each separated by DONE+IDLE, 3 resp_a pulses.
- read_b and write_b both high at address 16'h5000 → pmem_write issued, pmem_read never high, rdata_b unchanged after resp_b.
- rst_n pulsed low during SERVE, then pmem_resp delivered → pmem_* low immediately, no resp_a/resp_b, state IDLE, rdata registers 16'h0000.
- pmem_resp pulsed while IDLE with no requests → no resp on either port, no state change.

Source files
------------

// File: rtl/mem_arbiter_dp.sv
// Two-to-one arbiter serialising the LC-3 fetch (A) and data (B) ports onto one memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise B has fixed priority over A.
module mem_arbiter_dp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic        write_a,
  input  logic [1:0]  wmask_a,
  input  logic [15:0] address_a,
  input  logic [15:0] wdata_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned MW = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          grant_b_q, grant_b_d;
  logic          pend_a, pend_b, sel_b, sel_write;
  logic          pmem_read_d, pmem_write_d;
  logic [MW-1:0] pmem_wmask_d;
  logic [AW-1:0] pmem_address_d;
  logic [DW-1:0] pmem_wdata_d;
  logic          resp_a_d, resp_b_d;
  logic [DW-1:0] rdata_a_d, rdata_b_d;

  assign pend_a    = read_a | write_a;
  assign pend_b    = read_b | write_b;
  // A write request wins over a simultaneous read on the same port
  assign sel_write = sel_b ? write_b : write_a;

`ifdef ARB_ROUND_ROBIN_EN
  logic prefer_a_q, prefer_a_d;

  // The port not granted last wins a tie; a lone requester always wins
  always_comb begin
    sel_b      = pend_b & (~pend_a | ~prefer_a_q);
    prefer_a_d = prefer_a_q;
    if ((state_q == IDLE) && (pend_a || pend_b)) prefer_a_d = sel_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prefer_a_q <= 1'b1;
    else        prefer_a_q <= prefer_a_d;
  end
`else
  assign sel_b = pend_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next value of every registered output
  always_comb begin
    state_d        = state_q;
    grant_b_d      = grant_b_q;
    pmem_read_d    = pmem_read;
    pmem_write_d   = pmem_write;
    pmem_wmask_d   = pmem_wmask;
    pmem_address_d = pmem_address;
    pmem_wdata_d   = pmem_wdata;
    resp_a_d       = 1'b0;
    resp_b_d       = 1'b0;
    rdata_a_d      = rdata_a;
    rdata_b_d      = rdata_b;
    case (state_q)
      IDLE: begin
        if (pend_a || pend_b) begin
          state_d        = SERVE;
          grant_b_d      = sel_b;
          pmem_write_d   = sel_write;
          pmem_read_d    = ~sel_write;
          pmem_wmask_d   = sel_b ? wmask_b : wmask_a;
          pmem_address_d = sel_b ? address_b : address_a;
          pmem_wdata_d   = sel_b ? wdata_b : wdata_a;
        end
      end
      SERVE: begin
        if (pmem_resp) begin
          state_d      = DONE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          if (grant_b_q) begin
            resp_b_d = 1'b1;
            if (pmem_read) rdata_b_d = pmem_rdata;
          end else begin
            resp_a_d = 1'b1;
            if (pmem_read) rdata_a_d = pmem_rdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_b_q    <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wmask   <= MW'(0);
      pmem_address <= AW'(0);
      pmem_wdata   <= DW'(0);
      resp_a       <= 1'b0;
      resp_b       <= 1'b0;
      rdata_a      <= DW'(0);
      rdata_b      <= DW'(0);
    end else begin
      grant_b_q    <= grant_b_d;
      pmem_read    <= pmem_read_d;
      pmem_write   <= pmem_write_d;
      pmem_wmask   <= pmem_wmask_d;
      pmem_address <= pmem_address_d;
      pmem_wdata   <= pmem_wdata_d;
      resp_a       <= resp_a_d;
      resp_b       <= resp_b_d;
      rdata_a      <= rdata_a_d;
      rdata_b      <= rdata_b_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_dp.sv
// Bench for mem_arbiter_dp: scripted requesters, a delayed-response memory and a
// transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_arbiter_dp;

  logic clk = 1'b0;
  logic rst_n;
  logic read_a, write_a, read_b, write_b;
  logic [1:0] wmask_a, wmask_b;
  logic [15:0] address_a, wdata_a, address_b, wdata_b;
  logic resp_a, resp_b;
  logic [15:0] rdata_a, rdata_b;
  logic pmem_read, pmem_write, pmem_resp;
  logic [1:0] pmem_wmask;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;

  mem_arbiter_dp dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
    .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
    .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  mask;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  int n_checks, n_fail;

  req_t q_a[$], q_b[$];
  req_t cur [2];
  bit   cur_v [2];
  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  int mem_delay, mem_cnt;
  bit spur_en, force_resp, mem_busy, release_pending, prev_op;

  // Transaction-level model: one outstanding memory op, then a response cycle
  bit m_busy, m_show;
  int m_port;
  req_t m_req;
  logic [15:0] exp_rdata [2];
`ifdef ARB_ROUND_ROBIN_EN
  int last_port;
`endif

  int obs_cyc, n_pr_cyc, first_resp_a;
  int n_resp [2];
  req_t oplog[$];

  function automatic logic [15:0] init_word(input int a);
    return 16'(a) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] m);
    logic [15:0] r;
    r = old;
    if (m[0]) r[7:0] = wd[7:0];
    if (m[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  function automatic req_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wd, input logic [1:0] m);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wd; r.mask = m;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    int k;
    k = int'($urandom_range(0, 9));
    r.rd    = (k < 4) || (k == 8);
    r.wr    = (k >= 4) && (k <= 8);
    r.addr  = 16'h3000 | 16'($urandom_range(0, 15));
    r.wdata = 16'($urandom);
    r.mask  = 2'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic check1(input string name, input logic act, input logic want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_show = 0; m_port = 0; m_req = '0;
    exp_rdata[0] = 16'h0; exp_rdata[1] = 16'h0;
`ifdef ARB_ROUND_ROBIN_EN
    last_port = 1;
`endif
    cur_v[0] = 0; cur_v[1] = 0;
    q_a.delete(); q_b.delete();
    read_a = 0; write_a = 0; read_b = 0; write_b = 0;
  endtask

  task automatic start_test();
    obs_cyc = -1; n_pr_cyc = 0; first_resp_a = -1;
    n_resp[0] = 0; n_resp[1] = 0;
    oplog.delete();
  endtask

  // One clock: compare, then memory, requesters and model react for the next edge
  task automatic cycle();
    bit pend [2];
    bit seen [2];
    int win;
    req_t e;
    @(negedge clk);
    obs_cyc++;
    check1("pmem_read", pmem_read, m_busy && !m_req.wr);
    check1("pmem_write", pmem_write, m_busy && m_req.wr);
    check1("resp_a", resp_a, m_show && (m_port == 0));
    check1("resp_b", resp_b, m_show && (m_port == 1));
    check16("rdata_a", rdata_a, exp_rdata[0]);
    check16("rdata_b", rdata_b, exp_rdata[1]);
    if (m_busy) begin
      check16("pmem_address", pmem_address, m_req.addr);
      check16("pmem_wdata", pmem_wdata, m_req.wdata);
      check16("pmem_wmask", 16'(pmem_wmask), 16'(m_req.mask));
    end
    if (pmem_read) n_pr_cyc++;
    if ((pmem_read || pmem_write) && !prev_op)
      oplog.push_back(mk(pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask));
    prev_op = pmem_read || pmem_write;
    if (resp_a) begin
      n_resp[0]++;
      if (first_resp_a < 0) first_resp_a = obs_cyc;
    end
    if (resp_b) n_resp[1]++;
    if (release_pending) begin rst_n = 1'b1; release_pending = 0; end

    pmem_resp = 1'b0;
    pmem_rdata = 16'($urandom);
    if ((pmem_read || pmem_write) && rst_n) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_cnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end
      if (mem_cnt == 0) begin
        pmem_resp = 1'b1;
        mem_busy = 0;
        if (pmem_write) mem[pmem_address] = merge(mem[pmem_address], pmem_wdata, pmem_wmask);
        else pmem_rdata = mem[pmem_address];
      end else mem_cnt--;
    end else begin
      mem_busy = 0;
      if (force_resp || (spur_en && ($urandom_range(0, 7) == 0))) pmem_resp = 1'b1;
      force_resp = 0;
    end

    seen[0] = resp_a; seen[1] = resp_b;
    for (int p = 0; p < 2; p++) begin
      if (cur_v[p] && seen[p]) cur_v[p] = 0;
      if (!cur_v[p]) begin
        e = '0;
        if (p == 0 && q_a.size() > 0) e = q_a.pop_front();
        else if (p == 1 && q_b.size() > 0) e = q_b.pop_front();
        if (e.rd || e.wr) begin cur[p] = e; cur_v[p] = 1; end
      end
    end
    read_a    = cur_v[0] & cur[0].rd;
    write_a   = cur_v[0] & cur[0].wr;
    address_a = cur_v[0] ? cur[0].addr : 16'($urandom);
    wdata_a   = cur_v[0] ? cur[0].wdata : 16'($urandom);
    wmask_a   = cur_v[0] ? cur[0].mask : 2'($urandom);
    read_b    = cur_v[1] & cur[1].rd;
    write_b   = cur_v[1] & cur[1].wr;
    address_b = cur_v[1] ? cur[1].addr : 16'($urandom);
    wdata_b   = cur_v[1] ? cur[1].wdata : 16'($urandom);
    wmask_b   = cur_v[1] ? cur[1].mask : 2'($urandom);

    pend[0] = read_a | write_a;
    pend[1] = read_b | write_b;
    if (rst_n) begin
      if (m_busy) begin
        if (pmem_resp) begin
          m_busy = 0; m_show = 1;
          if (m_req.wr) ref_mem[m_req.addr] = merge(ref_mem[m_req.addr], m_req.wdata, m_req.mask);
          else exp_rdata[m_port] = ref_mem[m_req.addr];
        end
      end else if (m_show) begin
        m_show = 0;
      end else if (pend[0] || pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = (pend[0] && pend[1]) ? 1 - last_port : (pend[1] ? 1 : 0);
        last_port = win;
`else
        win = pend[1] ? 1 : 0;
`endif
        m_port = win; m_busy = 1; m_req = cur[win];
      end
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((q_a.size() > 0 || q_b.size() > 0 || cur_v[0] || cur_v[1] || m_busy || m_show)
           && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL drain: requests still outstanding after %0d cycles", budget);
    end
    cycle();
    cycle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    release_pending = 1;
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi, k;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b1; pmem_resp = 0; pmem_rdata = 0;
    wmask_a = 0; address_a = 0; wdata_a = 0; wmask_b = 0; address_b = 0; wdata_b = 0;
    mem_delay = -1; mem_cnt = 0; spur_en = 0; force_resp = 0; mem_busy = 0;
    release_pending = 0; prev_op = 0;
    for (int i = 0; i < 65536; i++) begin mem[i] = init_word(i); ref_mem[i] = mem[i]; end
    model_reset();
    #1;
    start_test();
    apply_reset();
    check1("reset pmem_read", pmem_read, 1'b0);
    check1("reset pmem_write", pmem_write, 1'b0);
    check1("reset resp_a", resp_a, 1'b0);
    check1("reset resp_b", resp_b, 1'b0);
    check16("reset rdata_a", rdata_a, 16'h0000);
    check16("reset rdata_b", rdata_b, 16'h0000);
    check16("reset pmem_address", pmem_address, 16'h0000);

    // Single read on A with a two-cycle memory delay
    mem[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
    mem_delay = 2;
    start_test();
    q_a.push_back(mk(1, 0, 16'h3000, 16'h0, 2'b00));
    drain(50);
    check16("t1 pmem_read cycles", 16'(n_pr_cyc), 16'd3);
    check16("t1 resp_a cycle", 16'(first_resp_a), 16'd4);
    check16("t1 resp_a count", 16'(n_resp[0]), 16'd1);
    check16("t1 rdata_a", rdata_a, 16'h1234);
    check16("t1 rdata_b", rdata_b, 16'h0000);

    // Simultaneous A read and B write straight after reset
    apply_reset();
    mem_delay = 1;
    start_test();
    q_a.push_back(mk(1, 0, 16'h3000, 16'h0, 2'b00));
    q_b.push_back(mk(0, 1, 16'h4000, 16'hBEEF, 2'b01));
    drain(50);
`ifdef ARB_ROUND_ROBIN_EN
    wi = 1;
`else
    wi = 0;
`endif
    check16("t2 op count", 16'(oplog.size()), 16'd2);
    if (oplog.size() == 2) begin
      check1("t2 write slot", oplog[wi].wr, 1'b1);
      check16("t2 write addr", oplog[wi].addr, 16'h4000);
      check16("t2 write data", oplog[wi].wdata, 16'hBEEF);
      check16("t2 write mask", 16'(oplog[wi].mask), 16'h0001);
      check1("t2 read slot", oplog[1 - wi].rd, 1'b1);
      check16("t2 read addr", oplog[1 - wi].addr, 16'h3000);
    end
    check16("t2 rdata_a", rdata_a, 16'h1234);
    check16("t2 rdata_b", rdata_b, 16'h0000);

    // Port A holds read across three back-to-back transactions
    mem_delay = 0;
    start_test();
    q_a.push_back(mk(1, 0, 16'h3000, 16'h0, 2'b00));
    q_a.push_back(mk(1, 0, 16'h3001, 16'h0, 2'b00));
    q_a.push_back(mk(1, 0, 16'h3002, 16'h0, 2'b00));
    drain(60);
    check16("t3 op count", 16'(oplog.size()), 16'd3);
    if (oplog.size() == 3) check16("t3 third addr", oplog[2].addr, 16'h3002);
    check16("t3 resp_a count", 16'(n_resp[0]), 16'd3);
    check16("t3 rdata_a", rdata_a, 16'h6A3E);

    // Read and write together on B become a write
    mem_delay = 1;
    start_test();
    q_b.push_back(mk(1, 1, 16'h5000, 16'hA55A, 2'b11));
    drain(50);
    check16("t4 pmem_read cycles", 16'(n_pr_cyc), 16'd0);
    check16("t4 op count", 16'(oplog.size()), 16'd1);
    check16("t4 resp_b count", 16'(n_resp[1]), 16'd1);
    check16("t4 rdata_b", rdata_b, 16'h0000);
    q_b.push_back(mk(1, 0, 16'h5000, 16'h0, 2'b00));
    drain(50);
    check16("t4 readback", rdata_b, 16'hA55A);

    // Reset pulsed while a read is being served
    mem_delay = 5;
    start_test();
    q_a.push_back(mk(1, 0, 16'h3001, 16'h0, 2'b00));
    k = 0;
    while (!pmem_read && k < 10) begin cycle(); k++; end
    check1("t5 serve reached", pmem_read, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check1("t5 async pmem_read", pmem_read, 1'b0);
    check1("t5 async pmem_write", pmem_write, 1'b0);
    check1("t5 async resp_a", resp_a, 1'b0);
    check16("t5 async rdata_a", rdata_a, 16'h0000);
    cycle();
    cycle();
    release_pending = 1;
    force_resp = 1;
    start_test();
    for (int i = 0; i < 6; i++) cycle();
    check16("t5 resp count", 16'(n_resp[0] + n_resp[1]), 16'd0);
    check16("t5 pmem ops", 16'(oplog.size()), 16'd0);

    // Spurious memory response while idle
    start_test();
    force_resp = 1;
    for (int i = 0; i < 5; i++) cycle();
    check16("t6 resp count", 16'(n_resp[0] + n_resp[1]), 16'd0);
    check16("t6 pmem ops", 16'(oplog.size()), 16'd0);

    // Random traffic on both ports with random delays and stray responses
    mem_delay = -1;
    spur_en = 1;
    start_test();
    for (int i = 0; i < 200; i++) begin
      q_a.push_back(rnd_req());
      q_b.push_back(rnd_req());
    end
    drain(20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
